// File: rtl/hazard_pkg.sv
// Shared forwarding codes and the register-match helper used by the hazard forwarding unit.
package hazard_pkg;

   localparam logic [1:0] FWD_NONE  = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   // Wide enough for any practical REG_AW; callers zero-extend with a size cast.
   localparam int unsigned IDX_W = 16;

   // x0 is hardwired to zero, so it never matches a producer.
   function automatic logic src_hit(input logic [IDX_W-1:0] idx,
                                    input logic             used,
                                    input logic [IDX_W-1:0] dst,
                                    input logic             we);
      return used & we & (idx != '0) & (idx == dst);
   endfunction

endpackage

// File: rtl/md_scoreboard.sv
// Tracks the single in-flight multi-cycle mul/div op: busy countdown and its destination.
module md_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned MD_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              launch,
   input  logic [REG_AW-1:0] dst,
   output logic              busy,
   output logic [REG_AW-1:0] busy_dst,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_dst
);

   localparam int unsigned CW = $clog2(MD_LAT + 1);

   logic [CW-1:0]     cnt;
   logic [REG_AW-1:0] md_dst;

   // An asynchronous reset aborts the op outright; no writeback pulse follows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         md_dst <= '0;
      end else if (launch) begin
         cnt    <= CW'(MD_LAT);
         md_dst <= dst;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   always_comb begin
      busy     = (cnt != '0);
      busy_dst = md_dst;
      wb_valid = (cnt == CW'(1));
      wb_dst   = wb_valid ? md_dst : '0;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use and mul/div hazard detection beside the ID/EX pipeline register.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned MD_LAT  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_used,
   input  logic [REG_AW-1:0]         id_dst,
   input  logic                      id_regwrite,
   input  logic                      id_is_load,
   input  logic                      id_is_md,
   input  logic                      flush,
   input  logic                      ex_mem_regwrite,
   input  logic [REG_AW-1:0]         ex_mem_dst,
   input  logic                      mem_wb_regwrite,
   input  logic [REG_AW-1:0]         mem_wb_dst,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic                      stall,
   output logic                      bubble,
   output logic                      md_start,
   output logic                      md_busy,
   output logic                      md_wb_valid,
   output logic [REG_AW-1:0]         md_wb_dst
);

   logic                      ex_valid;
   logic [NUM_SRC*REG_AW-1:0] ex_src;
   logic [NUM_SRC-1:0]        ex_src_used;
   logic [REG_AW-1:0]         ex_dst;
   logic                      ex_regwrite;
   logic                      ex_is_load;
   logic                      ex_is_md;

   logic                      issue;
   logic                      md_pend;
   logic [REG_AW-1:0]         md_pend_dst;
   logic [REG_AW-1:0]         md_busy_dst;
   logic [NUM_SRC-1:0]        lu_hit;
   logic [NUM_SRC-1:0]        md_hit;
   logic                      stall_lu;
   logic                      stall_md;

   // ID/EX shadow: fields only move on issue, ex_valid drops to form the bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_src      <= '0;
         ex_src_used <= '0;
         ex_dst      <= '0;
         ex_regwrite <= 1'b0;
         ex_is_load  <= 1'b0;
         ex_is_md    <= 1'b0;
      end else if (issue) begin
         ex_valid    <= 1'b1;
         ex_src      <= id_src;
         ex_src_used <= id_src_used;
         ex_dst      <= id_dst;
         ex_regwrite <= id_regwrite;
         ex_is_load  <= id_is_load;
         ex_is_md    <= id_is_md;
      end else begin
         ex_valid <= 1'b0;
      end
   end

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      logic [REG_AW-1:0] ex_s;
      logic [REG_AW-1:0] id_s;
      logic [1:0]        sel;

      assign ex_s = ex_src[k*REG_AW +: REG_AW];
      assign id_s = id_src[k*REG_AW +: REG_AW];

      // EX/MEM holds the younger result, so it takes priority over MEM/WB.
      always_comb begin
         sel = FWD_NONE;
         if (ex_valid) begin
            if (src_hit(IDX_W'(ex_s), ex_src_used[k], IDX_W'(ex_mem_dst), ex_mem_regwrite)) begin
               sel = FWD_EXMEM;
            end else if (src_hit(IDX_W'(ex_s), ex_src_used[k], IDX_W'(mem_wb_dst),
                                 mem_wb_regwrite)) begin
               sel = FWD_MEMWB;
            end
         end
      end

      assign fwd_sel[2*k +: 2] = sel;
      assign lu_hit[k] = src_hit(IDX_W'(id_s), id_src_used[k], IDX_W'(ex_dst), 1'b1);
      assign md_hit[k] = src_hit(IDX_W'(id_s), id_src_used[k], IDX_W'(md_pend_dst), 1'b1);

      fwd_code_legal: assert property (@(posedge clk) disable iff (!rst_n) sel != 2'b11);
   end

   // Before the counter loads, the pending MD op still sits in EX.
   always_comb begin
      md_pend     = md_busy | (ex_valid & ex_is_md);
      md_pend_dst = md_busy ? md_busy_dst : ex_dst;
   end

   always_comb begin
      stall_lu = id_valid & ex_valid & ex_is_load & ex_regwrite & (ex_dst != '0) & (|lu_hit);
      stall_md = id_valid & md_pend &
                 ((|md_hit) |
                  src_hit(IDX_W'(id_dst), id_regwrite, IDX_W'(md_pend_dst), 1'b1) |
                  id_is_md);
      stall    = stall_lu | stall_md;
      bubble   = stall | flush;
      issue    = id_valid & ~stall & ~flush;
      md_start = ex_valid & ex_is_md;
   end

   md_scoreboard #(
      .REG_AW (REG_AW),
      .MD_LAT (MD_LAT)
   ) u_md_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .launch   (md_start),
      .dst      (ex_dst),
      .busy     (md_busy),
      .busy_dst (md_busy_dst),
      .wb_valid (md_wb_valid),
      .wb_dst   (md_wb_dst)
   );

   md_start_idle: assert property (@(posedge clk) disable iff (!rst_n) md_start |-> !md_busy);
   md_wb_in_busy: assert property (@(posedge clk) disable iff (!rst_n) md_wb_valid |-> md_busy);

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scoreboard bench for hazard_forward_unit (REG_AW=5, NUM_SRC=2, MD_LAT=4).
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [9:0]  id_src;
   logic [1:0]  id_src_used;
   logic [4:0]  id_dst;
   logic        id_regwrite;
   logic        id_is_load;
   logic        id_is_md;
   logic        flush;
   logic        ex_mem_regwrite;
   logic [4:0]  ex_mem_dst;
   logic        mem_wb_regwrite;
   logic [4:0]  mem_wb_dst;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic        bubble;
   logic        md_start;
   logic        md_busy;
   logic        md_wb_valid;
   logic [4:0]  md_wb_dst;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] fwd;
      logic       stall;
      logic       bubble;
      logic       start;
      logic       busy;
      logic       wbv;
      logic [4:0] wbd;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   hazard_forward_unit #(
      .REG_AW  (5),
      .NUM_SRC (2),
      .MD_LAT  (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid        (id_valid),
      .id_src          (id_src),
      .id_src_used     (id_src_used),
      .id_dst          (id_dst),
      .id_regwrite     (id_regwrite),
      .id_is_load      (id_is_load),
      .id_is_md        (id_is_md),
      .flush           (flush),
      .ex_mem_regwrite (ex_mem_regwrite),
      .ex_mem_dst      (ex_mem_dst),
      .mem_wb_regwrite (mem_wb_regwrite),
      .mem_wb_dst      (mem_wb_dst),
      .fwd_sel         (fwd_sel),
      .stall           (stall),
      .bubble          (bubble),
      .md_start        (md_start),
      .md_busy         (md_busy),
      .md_wb_valid     (md_wb_valid),
      .md_wb_dst       (md_wb_dst)
   );

   task automatic cmp(input string tag, input string fld, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] fwd, input logic st,
                       input logic bu, input logic ms, input logic mb, input logic wv,
                       input logic [4:0] wd);
      exp_t e;
      e.tag = tag; e.fwd = fwd; e.stall = st; e.bubble = bu;
      e.start = ms; e.busy = mb; e.wbv = wv; e.wbd = wd;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end else begin
         e = sb.pop_front();
         cmp(e.tag, "fwd_sel", 8'(fwd_sel), 8'(e.fwd));
         cmp(e.tag, "stall", 8'(stall), 8'(e.stall));
         cmp(e.tag, "bubble", 8'(bubble), 8'(e.bubble));
         cmp(e.tag, "md_start", 8'(md_start), 8'(e.start));
         cmp(e.tag, "md_busy", 8'(md_busy), 8'(e.busy));
         cmp(e.tag, "md_wb_valid", 8'(md_wb_valid), 8'(e.wbv));
         cmp(e.tag, "md_wb_dst", 8'(md_wb_dst), 8'(e.wbd));
      end
   endtask

   // Inputs change just after posedge; outputs are sampled on the negedge.
   task automatic step();
      @(negedge clk);
      check_now();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic u0, input logic u1, input logic [4:0] d,
                         input logic rw, input logic ld, input logic md);
      id_valid = v; id_src = {s1, s0}; id_src_used = {u1, u0}; id_dst = d;
      id_regwrite = rw; id_is_load = ld; id_is_md = md;
   endtask

   task automatic set_fw(input logic exw, input logic [4:0] exd, input logic mww,
                         input logic [4:0] mwd);
      ex_mem_regwrite = exw; ex_mem_dst = exd; mem_wb_regwrite = mww; mem_wb_dst = mwd;
   endtask

   task automatic idle_id();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      idle_id();
      set_fw(1'b0, 5'd0, 1'b0, 5'd0);
      #3;
      push("reset", 4'b0000, 0, 0, 0, 0, 0, 5'd0);
      check_now();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Forwarding priority on operand 0
      set_id(1, 5'd5, 5'd6, 1, 1, 5'd10, 1, 0, 0);
      push("t1_issue", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_fw(1, 5'd5, 1, 5'd5);
      push("t1_exmem", 4'b0010, 0, 0, 0, 0, 0, 5'd0); step();
      set_fw(0, 5'd5, 1, 5'd5);
      push("t1_memwb", 4'b0001, 0, 0, 0, 0, 0, 5'd0); step();

      // x0 and unused-operand suppression
      set_fw(0, 5'd0, 0, 5'd0);
      set_id(1, 5'd3, 5'd0, 1, 1, 5'd11, 1, 0, 0);
      push("t2_issue", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_fw(1, 5'd0, 1, 5'd0);
      set_id(1, 5'd5, 5'd5, 0, 1, 5'd12, 1, 0, 0);
      push("t2_x0", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_fw(1, 5'd5, 1, 5'd5);
      idle_id();
      push("t2_unused", 4'b1000, 0, 0, 0, 0, 0, 5'd0); step();

      // Load-use: one stall cycle, then MEM/WB forward
      set_fw(0, 5'd0, 0, 5'd0);
      set_id(1, 5'd2, 5'd0, 1, 0, 5'd7, 1, 1, 0);
      push("t3_load", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_id(1, 5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 0);
      push("t3_stall", 4'b0000, 1, 1, 0, 0, 0, 5'd0); step();
      push("t3_release", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      idle_id();
      set_fw(0, 5'd0, 1, 5'd7);
      push("t3_fwd", 4'b0001, 0, 0, 0, 0, 0, 5'd0); step();

      // Flush during a load-use stall, then flush of an unstalled instruction
      set_fw(0, 5'd0, 0, 5'd0);
      set_id(1, 5'd2, 5'd0, 1, 0, 5'd7, 1, 1, 0);
      push("fl_load", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_id(1, 5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 0);
      flush = 1'b1;
      push("fl_stall", 4'b0000, 1, 1, 0, 0, 0, 5'd0); step();
      flush = 1'b0;
      idle_id();
      set_fw(1, 5'd7, 0, 5'd0);
      push("fl_noissue", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_fw(0, 5'd0, 0, 5'd0);
      set_id(1, 5'd4, 5'd0, 1, 0, 5'd15, 1, 0, 0);
      flush = 1'b1;
      push("fl_kill", 4'b0000, 0, 1, 0, 0, 0, 5'd0); step();
      flush = 1'b0;
      idle_id();
      set_fw(1, 5'd4, 0, 5'd0);
      push("fl_killed", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();

      // MD to x9 with a dependent reader
      set_fw(0, 5'd0, 0, 5'd0);
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 1);
      push("t4_mul", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_id(1, 5'd9, 5'd3, 1, 1, 5'd10, 1, 0, 0);
      push("t4_start", 4'b0000, 1, 1, 1, 0, 0, 5'd0); step();
      for (int i = 0; i < 3; i++) begin
         push("t4_busy", 4'b0000, 1, 1, 0, 1, 0, 5'd0); step();
      end
      push("t4_wb", 4'b0000, 1, 1, 0, 1, 1, 5'd9); step();
      push("t4_release", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      idle_id();
      set_fw(1, 5'd3, 0, 5'd0);
      push("t4_issued", 4'b1000, 0, 0, 0, 0, 0, 5'd0); step();

      // Second MD is structurally blocked; independent ALU ops flow
      set_fw(0, 5'd0, 0, 5'd0);
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd11, 1, 0, 1);
      push("t5_mul_a", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_id(1, 5'd4, 5'd5, 1, 1, 5'd12, 1, 0, 1);
      push("t5_start_a", 4'b0000, 1, 1, 1, 0, 0, 5'd0); step();
      for (int i = 0; i < 3; i++) begin
         push("t5_busy", 4'b0000, 1, 1, 0, 1, 0, 5'd0); step();
      end
      push("t5_wb_a", 4'b0000, 1, 1, 0, 1, 1, 5'd11); step();
      push("t5_release", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      set_id(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0, 0);
      push("t5_start_b", 4'b0000, 0, 0, 1, 0, 0, 5'd0); step();
      set_id(1, 5'd4, 5'd5, 1, 1, 5'd14, 1, 0, 0);
      push("t5_indep", 4'b0000, 0, 0, 0, 1, 0, 5'd0); step();
      idle_id();
      push("t5_busy3", 4'b0000, 0, 0, 0, 1, 0, 5'd0); step();

      // Asynchronous reset with the counter at 2 aborts the op
      push("t6_busy2", 4'b0000, 0, 0, 0, 1, 0, 5'd0);
      @(negedge clk);
      check_now();
      #2;
      rst_n = 1'b0;
      #1;
      push("t6_rst", 4'b0000, 0, 0, 0, 0, 0, 5'd0);
      check_now();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push("t6_after", 4'b0000, 0, 0, 0, 0, 0, 5'd0); step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
